// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the iterative restoring divider.
//   state_t   - controller states (idle, calculating, result presented)
//   cnt_width - bit counter width able to hold the value DATA_WIDTH_1
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational radix-2 restoring division step.
//   pr        in  DATA_WIDTH_2  partial remainder (always < divisor)
//   bit_in    in  1             next dividend bit, shifted into the LSB
//   divisor   in  DATA_WIDTH_2  divisor
//   new_pr    out DATA_WIDTH_2  partial remainder after compare/subtract
//   q_bit     out 1             resulting quotient bit
module divider_step #(
    parameter int unsigned DATA_WIDTH_2 = 8
) (
    input  logic [DATA_WIDTH_2-1:0] pr,
    input  logic                    bit_in,
    input  logic [DATA_WIDTH_2-1:0] divisor,
    output logic [DATA_WIDTH_2-1:0] new_pr,
    output logic                    q_bit
);

    // The shifted value needs one extra bit; after a successful subtract the
    // result is below the divisor, so a DATA_WIDTH_2-bit difference is exact.
    logic [DATA_WIDTH_2:0] shifted;

    always_comb begin
        shifted = {pr, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        new_pr  = q_bit ? (shifted[DATA_WIDTH_2-1:0] - divisor)
                        : shifted[DATA_WIDTH_2-1:0];
    end

endmodule

// File: rtl/divider.sv
// divider: iterative unsigned restoring divider, one quotient bit per clock,
// behind a start/busy/done handshake.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start_i        request; operands sampled when accepted (IDLE or DONE)
//   data1_i        dividend, DATA_WIDTH_1 bits
//   data2_i        divisor, DATA_WIDTH_2 bits
//   busy_o         high while calculating
//   done_o         one-cycle pulse, results valid
//   quotient_o     quotient (all ones on divide by zero)
//   remainder_o    remainder (zero on divide by zero)
//   div_by_zero_o  set together with done_o when the divisor was zero
module divider
    import divider_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_1 = 16,
    parameter int unsigned DATA_WIDTH_2 = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [DATA_WIDTH_1-1:0] data1_i,
    input  logic [DATA_WIDTH_2-1:0] data2_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DATA_WIDTH_1-1:0] quotient_o,
    output logic [DATA_WIDTH_2-1:0] remainder_o,
    output logic                    div_by_zero_o
);

    localparam int unsigned CW = cnt_width(DATA_WIDTH_1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH_1);

    state_t state, state_nxt;

    logic [CW-1:0]           count;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so one register serves as both operand and quotient shifter.
    logic [DATA_WIDTH_1-1:0] shift_q;
    logic [DATA_WIDTH_2-1:0] divisor_q;
    logic [DATA_WIDTH_2-1:0] pr_q;

    logic [DATA_WIDTH_2-1:0] pr_nxt;
    logic                    q_bit;
    logic                    accept;
    logic                    zero_div;
    logic                    last_step;

    divider_step #(
        .DATA_WIDTH_2(DATA_WIDTH_2)
    ) u_step (
        .pr      (pr_q),
        .bit_in  (shift_q[DATA_WIDTH_1-1]),
        .divisor (divisor_q),
        .new_pr  (pr_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        accept    = start_i && (state != ST_CALC);
        zero_div  = (data2_i == '0);
        // The final step is folded into the CALC->DONE edge so that CALC
        // lasts exactly DATA_WIDTH_1 cycles.
        last_step = (state == ST_CALC) && (count == CW'(1));
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done_o = (state == ST_DONE);
                if (accept) begin
                    state_nxt = zero_div ? ST_DONE : ST_CALC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                busy_o = 1'b1;
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            shift_q       <= '0;
            divisor_q     <= '0;
            pr_q          <= '0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else if (accept) begin
            shift_q   <= data1_i;
            divisor_q <= data2_i;
            pr_q      <= '0;
            count     <= CNT_LOAD;
            if (zero_div) begin
                quotient_o    <= '1;
                remainder_o   <= '0;
                div_by_zero_o <= 1'b1;
            end
        end else if (state == ST_CALC) begin
            shift_q <= {shift_q[DATA_WIDTH_1-2:0], q_bit};
            pr_q    <= pr_nxt;
            count   <= count - CW'(1);
            if (last_step) begin
                quotient_o    <= {shift_q[DATA_WIDTH_1-2:0], q_bit};
                remainder_o   <= pr_nxt;
                div_by_zero_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

    localparam int unsigned W1 = 16;
    localparam int unsigned W2 = 8;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [W1-1:0] data1_i;
    logic [W2-1:0] data2_i;
    logic          busy_o;
    logic          done_o;
    logic [W1-1:0] quotient_o;
    logic [W2-1:0] remainder_o;
    logic          div_by_zero_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    divider #(
        .DATA_WIDTH_1(W1),
        .DATA_WIDTH_2(W2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .data1_i       (data1_i),
        .data2_i       (data2_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive a request so it is sampled on the next rising edge, then drop it.
    task automatic issue(input int unsigned a, input int unsigned b);
        start_i = 1'b1;
        data1_i = W1'(a);
        data2_i = W2'(b);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Wait for done after an accepted request and compare against plain
    // integer division. Returns at the falling edge where done_o is high.
    // poke: pulse an unrelated request a few cycles into the calculation.
    task automatic wait_done(input string tag, input int unsigned a, input int unsigned b,
                             input bit poke);
        int unsigned lat;
        int unsigned busy_n;
        bit          seen;
        int unsigned exp_q;
        int unsigned exp_r;
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (poke && i == 4) start_i = 1'b0;
            if (done_o) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (busy_o) busy_n++;
            if (poke && i == 3) begin
                start_i = 1'b1;
                data1_i = W1'(5);
                data2_i = W2'(1);
            end
        end
        start_i = 1'b0;
        if (b == 0) begin
            exp_q = (1 << W1) - 1;
            exp_r = 0;
        end else begin
            exp_q = a / b;
            exp_r = a % b;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, lat, (b == 0) ? 32'd0 : W1);
        check({tag, "_busy_cycles"}, busy_n, (b == 0) ? 32'd0 : W1);
        check({tag, "_quotient"}, 32'(quotient_o), exp_q);
        check({tag, "_remainder"}, 32'(remainder_o), exp_r);
        check({tag, "_dbz"}, 32'(div_by_zero_o), (b == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_op(input string tag, input int unsigned a, input int unsigned b);
        @(negedge clk);
        issue(a, b);
        wait_done(tag, a, b, 1'b0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        int unsigned ra;
        int unsigned rb;
        rst_n   = 1'b0;
        start_i = 1'b0;
        data1_i = '0;
        data2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_quot", 32'(quotient_o), 32'd0);
        check("rst_rem", 32'(remainder_o), 32'd0);
        check("rst_dbz", 32'(div_by_zero_o), 32'd0);
        rst_n = 1'b1;

        run_op("d748_22", 748, 22);
        run_op("d1000_7", 1000, 7);
        run_op("d9801_99", 9801, 99);
        run_op("d255_0", 255, 0);
        run_op("d306_9", 306, 9);
        // results hold after returning to idle
        @(negedge clk);
        check("hold_quot", 32'(quotient_o), 32'd34);
        check("hold_busy", 32'(busy_o), 32'd0);

        // request during calculation is ignored
        @(negedge clk);
        issue(748, 22);
        wait_done("ignore", 748, 22, 1'b1);
        // back-to-back: new request accepted while done is shown
        issue(65535, 255);
        wait_done("b2b", 65535, 255, 1'b0);
        @(negedge clk);
        check("b2b_done_pulse", 32'(done_o), 32'd0);

        // reset in the middle of a calculation
        @(negedge clk);
        issue(1000, 7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_quot", 32'(quotient_o), 32'd0);
        check("midrst_rem", 32'(remainder_o), 32'd0);
        check("midrst_dbz", 32'(div_by_zero_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done_o), 32'd0);
        end
        run_op("d20_3", 20, 3);

        // boundaries
        run_op("d0_1", 0, 1);
        run_op("d65535_1", 65535, 1);
        run_op("d0_255", 0, 255);
        run_op("d65534_255", 65534, 255);
        run_op("d7_200", 7, 200);

        // random sweep
        for (int unsigned n = 0; n < 40; n++) begin
            ra = $urandom_range(0, 65535);
            rb = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
            run_op("rand", ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
